// File: rtl/dii_package.sv
// dii_package: debug interconnect flit type shared by all debug modules
//   dii_flit - valid / last / 16-bit data, one flit per transfer
package dii_package;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

// File: rtl/osd_uart_package.sv
// osd_uart_package: constants and types shared by the UART debug module paths
//   OSD_EVENT_TYPE / OSD_UART_SUBTYPE - header values of a UART character event
//   HDR_* - bit offsets of the fields in header flit 1
//   rx_state_e - host-to-device packet parser states
package osd_uart_package;
    localparam logic [1:0] OSD_EVENT_TYPE   = 2'b01;
    localparam logic [3:0] OSD_UART_SUBTYPE = 4'h1;
    localparam int HDR_TYPE_MSB    = 15;
    localparam int HDR_TYPE_LSB    = 14;
    localparam int HDR_SUBTYPE_MSB = 13;
    localparam int HDR_SUBTYPE_LSB = 10;
    typedef enum logic [1:0] {DEST, HDR, PAYLOAD, DISCARD} rx_state_e;
endpackage

// File: rtl/osd_uart_char_fifo.sv
// osd_uart_char_fifo: first-word fall-through character FIFO
//   clk, rst          - clock, synchronous active-high reset
//   push, push_data   - write a character (ignored when full)
//   full              - no free entry
//   pop               - remove the head character (ignored when empty)
//   head, empty       - head character (8'h00 when empty), FIFO empty
module osd_uart_char_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    // One extra pointer bit tells a full FIFO from an empty one.
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    always_comb begin
        full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        empty = wr_q == rd_q;
        wr_d  = (push && !full) ? wr_q + (AW+1)'(1) : wr_q;
        rd_d  = (pop && !empty) ? rd_q + (AW+1)'(1) : rd_q;
        head  = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_q[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/osd_dem_uart_rx.sv
// osd_dem_uart_rx: host-to-device UART path, unwraps character event packets into a FIFO
//   clk, rst        - clock, synchronous active-high reset
//   debug_in        - incoming packet flits; debug_in_ready accepts them
//   id              - own module address compared against the destination flit
//   in_char, in_valid, in_ready - device-side character stream (FWFT)
//   drop_count      - saturating count of discarded packets; only built when
//                     OSD_DEM_UART_RX_STATS_EN is defined, otherwise tied to 0
module osd_dem_uart_rx
    import dii_package::*;
    import osd_uart_package::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  dii_flit     debug_in,
    output logic        debug_in_ready,
    input  logic [9:0]  id,
    output logic [7:0]  in_char,
    output logic        in_valid,
    input  logic        in_ready,
    output logic [15:0] drop_count
);
    rx_state_e state_q, state_d;
    logic full, empty, xfer, push, drop, hdr_match;
    always_comb begin
        hdr_match = debug_in.data[HDR_TYPE_MSB:HDR_TYPE_LSB] == OSD_EVENT_TYPE &&
                    debug_in.data[HDR_SUBTYPE_MSB:HDR_SUBTYPE_LSB] == OSD_UART_SUBTYPE;
        // Back-pressure only looks at the registered full flag, never at in_ready.
        debug_in_ready = (state_q == PAYLOAD) ? !full : 1'b1;
        xfer  = debug_in.valid && debug_in_ready;
        push  = xfer && state_q == PAYLOAD;
        state_d = state_q;
        drop  = 1'b0;
        if (xfer) begin
            case (state_q)
                DEST: begin
                    if (debug_in.last) drop = 1'b1;
                    else if (debug_in.data == {6'b0, id}) state_d = HDR;
                    else begin
                        state_d = DISCARD;
                        drop    = 1'b1;
                    end
                end
                HDR: begin
                    if (debug_in.last) begin
                        state_d = DEST;
                        drop    = 1'b1;
                    end else if (hdr_match) state_d = PAYLOAD;
                    else begin
                        state_d = DISCARD;
                        drop    = 1'b1;
                    end
                end
                PAYLOAD: state_d = debug_in.last ? DEST : PAYLOAD;
                DISCARD: state_d = debug_in.last ? DEST : DISCARD;
                default: state_d = DEST;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) state_q <= DEST;
        else state_q <= state_d;
    end
    osd_uart_char_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(debug_in.data[7:0]),
        .full     (full),
        .pop      (in_valid && in_ready),
        .head     (in_char),
        .empty    (empty)
    );
    assign in_valid = !empty;
`ifdef OSD_DEM_UART_RX_STATS_EN
    logic [15:0] drop_count_q, drop_count_d;
    always_comb drop_count_d = (drop && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
    always_ff @(posedge clk) begin
        if (rst) drop_count_q <= '0;
        else drop_count_q <= drop_count_d;
    end
    assign drop_count = drop_count_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign drop_count  = 16'h0000;
`endif
endmodule
